// File: rtl/riscv_alu.sv
// Registered RV32I execute-stage ALU: compute ops load result, branch compares load flag,
// both outputs settle one clock after the operands and opcode are sampled.
module riscv_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  ALUOp,
  output logic        flag,
  output logic [31:0] result
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_EQ   = 5'b11000;
  localparam logic [4:0] OP_NE   = 5'b11001;
  localparam logic [4:0] OP_LT   = 5'b11100;
  localparam logic [4:0] OP_GE   = 5'b11101;
  localparam logic [4:0] OP_LTU  = 5'b11110;
  localparam logic [4:0] OP_GEU  = 5'b11111;

  logic [31:0] result_d;
  logic        flag_d;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;

  // Only the low five bits of B take part in shifts, so a shift by 32 is a shift by 0.
  assign shamt = B[4:0];
  assign lt_s  = $signed(A) < $signed(B);
  assign lt_u  = A < B;

  always_comb begin
    result_d = 32'h0;
    flag_d   = 1'b0;
    case (ALUOp)
      OP_ADD:  result_d = A + B;
      OP_SUB:  result_d = A - B;
      OP_SLL:  result_d = A << shamt;
      OP_SLT:  result_d = {31'b0, lt_s};
      OP_SLTU: result_d = {31'b0, lt_u};
      OP_XOR:  result_d = A ^ B;
      OP_SRL:  result_d = A >> shamt;
      OP_SRA:  result_d = $unsigned($signed(A) >>> shamt);
      OP_OR:   result_d = A | B;
      OP_AND:  result_d = A & B;
      OP_EQ:   flag_d   = (A == B);
      OP_NE:   flag_d   = (A != B);
      OP_LT:   flag_d   = lt_s;
      OP_GE:   flag_d   = !lt_s;
      OP_LTU:  flag_d   = lt_u;
      OP_GEU:  flag_d   = !lt_u;
      default: begin
        result_d = 32'h0;
        flag_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= 32'h0;
      flag   <= 1'b0;
    end else begin
      result <= result_d;
      flag   <= flag_d;
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Bench for riscv_alu: directed vectors from the operation table, then random operations
// checked against an arithmetic reference model through an expected-value queue.
module tb_riscv_alu;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ALUOp;
  logic        flag;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  // Expected {flag, result} per issued operation, oldest first.
  logic [32:0] exp_q[$];
  logic [32:0] last_exp;

  riscv_alu dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .ALUOp  (ALUOp),
    .flag   (flag),
    .result (result)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Reference model: plain arithmetic from the operation table.
  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        f;
    int          sh;
    r  = 32'h0;
    f  = 1'b0;
    sh = int'(b % 32);
    case (op)
      5'b00000: r = a + b;
      5'b01000: r = a - b;
      5'b00001: r = a << sh;
      5'b00010: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      5'b00011: r = (a < b) ? 32'd1 : 32'd0;
      5'b00100: r = a ^ b;
      5'b00101: r = a >> sh;
      5'b01101: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      5'b11000: f = (a == b);
      5'b11001: f = (a != b);
      5'b11100: f = (int'(a) < int'(b));
      5'b11101: f = (int'(a) >= int'(b));
      5'b11110: f = (a < b);
      5'b11111: f = (a >= b);
      default: begin
        r = 32'h0;
        f = 1'b0;
      end
    endcase
    return {f, r};
  endfunction

  task automatic check_out(input string tag, input logic [32:0] e);
    checks++;
    assert ({flag, result} === e)
    else begin
      errors++;
      $error("FAIL %s: got flag=%0b result=%h, expected flag=%0b result=%h",
             tag, flag, result, e[32], e[31:0]);
    end
  endtask

  // Driver: called at a falling edge. Drives inputs, confirms the outputs still hold the
  // previous value, then checks the new value just after the next rising edge.
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [32:0] e;
    ALUOp = op;
    A     = a;
    B     = b;
    exp_q.push_back(model(op, a, b));
    #1;
    check_out({tag, "_hold"}, last_exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_out(tag, e);
    last_exp = e;
  endtask

  task automatic step(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    issue(tag, op, a, b);
  endtask

  logic [4:0] valid_ops[16] = '{5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                5'b00101, 5'b01101, 5'b00110, 5'b00111, 5'b11000, 5'b11001,
                                5'b11100, 5'b11101, 5'b11110, 5'b11111};

  initial begin
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    last_exp = 33'h0;

    // Reset is visible before any clock edge
    rst   = 1'b1;
    A     = $urandom;
    B     = $urandom;
    ALUOp = 5'b00000;
    #2;
    check_out("reset_async_initial", 33'h0);
    @(posedge clk);
    #1;
    check_out("reset_held_over_edge", 33'h0);
    @(negedge clk);
    rst = 1'b0;
    issue("add_7_6", 5'b00000, 32'd7, 32'd6);

    step("sub_10_6",       5'b01000, 32'd10, 32'd6);
    step("sub_0_1",        5'b01000, 32'd0, 32'd1);
    step("add_wrap",       5'b00000, 32'hFFFF_FFFF, 32'd1);
    step("sll_10_6",       5'b00001, 32'd10, 32'd6);
    step("srl_6_3",        5'b00101, 32'd6, 32'd3);
    step("sra_neg",        5'b01101, 32'h8000_0000, 32'd4);
    step("sll_b_hi_bits",  5'b00001, 32'd1, 32'h0000_0021);
    step("sll_by_32",      5'b00001, 32'h1234_5678, 32'd32);
    step("sra_by_31",      5'b01101, 32'h8000_0000, 32'd31);
    step("xor_7_5",        5'b00100, 32'd7, 32'd5);
    step("or_12_3",        5'b00110, 32'd12, 32'd3);
    step("and_12_10",      5'b00111, 32'd12, 32'd10);
    step("slt_m2_3",       5'b00010, 32'hFFFF_FFFE, 32'd3);
    step("sltu_m2_3",      5'b00011, 32'hFFFF_FFFE, 32'd3);
    step("sltu_10_9",      5'b00011, 32'd10, 32'd9);
    step("sltu_9_10",      5'b00011, 32'd9, 32'd10);
    step("eq_5_5",         5'b11000, 32'd5, 32'd5);
    step("ne_5_5",         5'b11001, 32'd5, 32'd5);
    step("lt_m1_0",        5'b11100, 32'hFFFF_FFFF, 32'd0);
    step("ltu_m1_0",       5'b11110, 32'hFFFF_FFFF, 32'd0);
    step("ge_3_3",         5'b11101, 32'd3, 32'd3);
    step("geu_0_1",        5'b11111, 32'd0, 32'd1);
    step("illegal_01001",  5'b01001, 32'hDEAD_BEEF, 32'h1234_5678);
    step("add_after_ill",  5'b00000, 32'd100, 32'd23);

    // Mid-stream reset clears the registered value without waiting for a clock
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_out("reset_async_midstream", 33'h0);
    last_exp = 33'h0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_out("reset_mid_held", 33'h0);
    @(negedge clk);
    rst = 1'b0;
    issue("add_after_reset", 5'b00000, 32'd7, 32'd6);

    // Random back-to-back operations, including unassigned encodings
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else op = valid_ops[$urandom_range(0, 15)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000 | 32'($urandom_range(0, 3));
      step("random", op, a, b);
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_alu.md
# riscv_alu

Registered 32-bit integer ALU for the RV32I execute stage. It performs arithmetic, logic, shift and set-less-than operations, producing a 32-bit `result`. It also evaluates branch comparisons, producing a 1-bit `flag`. Operands and the 5-bit operation code come from the decoder and register file; outputs feed write-back and branch logic one clock later.

## Interface
- No parameters; data width fixed at 32 bits, opcode width fixed at 5 bits.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `A`  input  32  operand A.
- `B`  input  32  operand B; shifts use `B[4:0]` as shift amount.
- `ALUOp`  input  5  operation select.
- `flag`  output  1  registered comparison outcome.
- `result`  output  32  registered computation result.

## Operation
Compute operations load `result` and force `flag` = 0:
- `00000` ADD: A + B, modulo 2^32, carry discarded.
- `01000` SUB: A − B, modulo 2^32.
- `00001` SLL: A << B[4:0]; B[31:5] ignored.
- `00010` SLT: {31'b0, $signed(A) < $signed(B)}.
- `00011` SLTU: {31'b0, A < B}, unsigned.
- `00100` XOR: A ^ B.
- `00101` SRL: A >> B[4:0], zero fill.
- `01101` SRA: A >>> B[4:0], sign fill from A[31].
- `00110` OR: A | B.
- `00111` AND: A & B.

Compare operations load `flag` and force `result` = 0:
- `11000` EQ: A == B.
- `11001` NE: A != B.
- `11100` LT: signed A < B.
- `11101` GE: signed A >= B.
- `11110` LTU: unsigned A < B.
- `11111` GEU: unsigned A >= B.

Other behaviour:
- Any other `ALUOp` encoding sets `result` = 0 and `flag` = 0. No error indication.
- The next-state values are computed combinationally from the current A, B and ALUOp. There is no internal state other than the two output registers.

## Timing
- While `rst` = 1: `result` = 32'h0 and `flag` = 0, immediately and independent of `clk`.
- After `rst` deasserts: on each rising edge of `clk`, inputs are sampled and the outputs update.
- Latency is exactly one cycle: inputs present before edge N appear on the outputs after edge N.
- Throughput is one operation per cycle. There is no handshake or stall; the outputs are overwritten every cycle.
- Outputs hold their values between edges. Input changes between edges have no effect on the outputs.
- If reset is asserted mid-stream, the in-flight value is lost. The first edge after deassertion produces the result of the inputs present at that edge.
- Overflow is never flagged. ADD and SUB wrap around: 32'hFFFFFFFF + 1 = 0, and 0 − 1 = 32'hFFFFFFFF.
- Shift by 0 returns A unchanged. Shift by 31 is the maximum; B = 32 behaves as a shift by 0.

## Test plan
- Reset: assert `rst` with random inputs → `result` = 0 and `flag` = 0 asynchronously, before any clock edge. Deassert, apply ADD 7, 6 → `result` = 13 after one edge.
- Arithmetic: SUB 10, 6 → 4. SUB 0, 1 → 32'hFFFFFFFF. ADD 32'hFFFFFFFF, 1 → 0. `flag` = 0 in all cases.
- Shifts and logic:
  - SLL 10, 6 → 640.
  - SRL 6, 3 → 0.
  - SRA 32'h80000000, 4 → 32'hF8000000.
  - SLL 1, 32'h00000021 → 2 (uses B[4:0] only).
  - XOR 7, 5 → 2. OR 12, 3 → 15. AND 12, 10 → 8.
- Set-less-than: SLT −2, 3 → 1. SLTU −2, 3 → 0. SLTU 10, 9 → 0. SLTU 9, 10 → 1.
- Branch compares, each with `result` = 0:
  - EQ 5, 5 → `flag` = 1.
  - NE 5, 5 → `flag` = 0.
  - LT −1, 0 → `flag` = 1.
  - LTU −1, 0 → `flag` = 0.
  - GE 3, 3 → `flag` = 1.
  - GEU 0, 1 → `flag` = 0.
- Pipelining and illegal code:
  - Back-to-back ops on consecutive edges each appear exactly one cycle later.
  - `ALUOp` = `01001` → `result` = 0, `flag` = 0.
